// File: rtl/alu_demo_ctrl.sv
// Operator-entry sequencer for an external ALU: debounced button, nibble entry of A/B/op, result capture.
// Field/state update 1 cycle after an accepted press, display 1 cycle later; optional RESULT_HIST_EN adds a 4-deep result history.
module alu_demo_ctrl #(
  parameter int DATA_W       = 16,
  parameter int OP_W         = 8,
  parameter int SW_W         = 10,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cont,
  input  logic [SW_W-1:0]   sw,
  input  logic [DATA_W-1:0] alu_c,
  input  logic [4:0]        alu_flags,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] digits,
  output logic [3:0]        mode_digit,
  output logic [4:0]        flag_leds,
  output logic [2:0]        state
);

  localparam logic [2:0] RST_S  = 3'd0;
  localparam logic [2:0] IN_A   = 3'd1;
  localparam logic [2:0] IN_B   = 3'd2;
  localparam logic [2:0] IN_OP  = 3'd3;
  localparam logic [2:0] SHOW_C = 3'd4;
  localparam int         CNT_W  = $clog2(DEBOUNCE_CYC + 1);

  logic              commit;
  logic              mod;
  logic [3:0]        nib;
  logic              sw_unused;
  logic [1:0]        sync_q;
  logic              cont_s;
  logic              db_down;
  logic [CNT_W-1:0]  db_cnt;
  logic              press;
  logic              cap_pend;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] shown;
  logic [DATA_W-1:0] chain_src;

  assign commit    = sw[SW_W-1];
  assign mod       = sw[SW_W-2];
  assign nib       = sw[3:0];
  assign sw_unused = ^sw;
  assign cont_s    = sync_q[1];

  // Button is active-low; synchroniser resets to the released level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], cont};
    end
  end

  // Debounced level toggles only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_down <= 1'b0;
      db_cnt  <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if ((~cont_s) != db_down) begin
        if (db_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
          db_down <= ~db_down;
          db_cnt  <= '0;
          press   <= ~db_down;
        end else begin
          db_cnt <= db_cnt + CNT_W'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

`ifdef RESULT_HIST_EN
  logic [DATA_W-1:0] hist [4];
  logic [1:0]        head;
  logic [1:0]        view;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      head <= 2'd0;
      view <= 2'd0;
    end else if (state == SHOW_C) begin
      if (cap_pend) begin
        hist[head + 2'd1] <= alu_c;
        head              <= head + 2'd1;
        view              <= 2'd0;
      end else if (press && !commit) begin
        view <= view + 2'd1;
      end
    end
  end

  assign shown = hist[head - view];
`else
  assign shown = res_q;
`endif

  // A chain press landing on the capture cycle must see the fresh ALU result.
  assign chain_src = cap_pend ? alu_c : shown;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST_S;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      res_q     <= '0;
      flag_leds <= '0;
      cap_pend  <= 1'b0;
    end else begin
      cap_pend <= 1'b0;
      case (state)
        RST_S: state <= IN_A;
        IN_A: if (press) begin
          if (commit)   state <= IN_B;
          else if (mod) alu_a <= '0;
          else          alu_a <= DATA_W'({alu_a, nib});
        end
        IN_B: if (press) begin
          if (commit)   state <= IN_OP;
          else if (mod) alu_b <= '0;
          else          alu_b <= DATA_W'({alu_b, nib});
        end
        IN_OP: if (press) begin
          if (commit) begin
            state    <= SHOW_C;
            cap_pend <= 1'b1;
          end else if (mod) begin
            alu_op <= '0;
          end else begin
            alu_op <= OP_W'({alu_op, nib});
          end
        end
        SHOW_C: begin
          if (cap_pend) begin
            res_q     <= alu_c;
            flag_leds <= alu_flags;
          end
          if (press && commit) begin
            if (mod) begin
              alu_a <= chain_src;
              alu_b <= '0;
              state <= IN_B;
            end else begin
              state <= IN_A;
            end
          end
        end
        default: state <= RST_S;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digits     <= '0;
      mode_digit <= 4'hF;
    end else begin
      case (state)
        IN_A: begin
          mode_digit <= 4'hA;
          digits     <= alu_a;
        end
        IN_B: begin
          mode_digit <= 4'hB;
          digits     <= alu_b;
        end
        IN_OP: begin
          mode_digit <= 4'h0;
          digits     <= DATA_W'(alu_op);
        end
        SHOW_C: begin
          mode_digit <= 4'hC;
          digits     <= shown;
        end
        default: begin
          mode_digit <= 4'hF;
          digits     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_demo_ctrl.sv
// Bench for alu_demo_ctrl: directed scenarios plus random presses against an abstract operator model.
module tb_alu_demo_ctrl;
  localparam int DW  = 16;
  localparam int OW  = 8;
  localparam int SWW = 10;
  localparam int DEB = 4;
  localparam int HOLD = DEB + 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          cont;
  logic [SWW-1:0] sw;
  logic [DW-1:0] alu_c;
  logic [4:0]    alu_flags;
  logic [DW-1:0] alu_a, alu_b, digits;
  logic [OW-1:0] alu_op;
  logic [3:0]    mode_digit;
  logic [4:0]    flag_leds;
  logic [2:0]    state;

  int checks = 0;
  int failures = 0;

  alu_demo_ctrl #(.DATA_W(DW), .OP_W(OW), .SW_W(SWW), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .reset(reset), .cont(cont), .sw(sw), .alu_c(alu_c), .alu_flags(alu_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .digits(digits),
    .mode_digit(mode_digit), .flag_leds(flag_leds), .state(state)
  );

  always #5 clk = ~clk;

  // Bench ALU: adder, flags mirror the low opcode bits so flag capture is observable.
  assign alu_c     = alu_a + alu_b;
  assign alu_flags = alu_op[4:0];

  // Operator model: 1=A entry, 2=B entry, 3=op entry, 4=showing result.
  int        m_state;
  bit [15:0] m_a, m_b, m_res;
  bit [7:0]  m_op;
  bit [4:0]  m_flags;
  bit [15:0] m_hist[$];
  int        m_view;

  function automatic void m_reset();
    m_state = 1; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flags = 0; m_view = 0;
    m_hist.delete();
  endfunction

  function automatic bit [15:0] m_shown();
`ifdef RESULT_HIST_EN
    return (m_view < m_hist.size()) ? m_hist[m_view] : 16'h0;
`else
    return m_res;
`endif
  endfunction

  function automatic void m_press(bit commit, bit mod, bit [3:0] nib);
    if (m_state == 4) begin
      if (commit && mod) begin
        m_a = m_shown(); m_b = 0; m_state = 2;
      end else if (commit) begin
        m_state = 1;
      end else begin
`ifdef RESULT_HIST_EN
        m_view = (m_view + 1) % 4;
`endif
      end
    end else if (commit) begin
      m_state = m_state + 1;
      if (m_state == 4) begin
        m_res = m_a + m_b; m_flags = m_op[4:0]; m_view = 0;
        m_hist.push_front(m_res);
        if (m_hist.size() > 4) void'(m_hist.pop_back());
      end
    end else if (m_state == 1) m_a = mod ? 16'h0 : ((m_a << 4) | 16'(nib));
    else if (m_state == 2)     m_b = mod ? 16'h0 : ((m_b << 4) | 16'(nib));
    else                       m_op = mod ? 8'h0 : ((m_op << 4) | 8'(nib));
  endfunction

  function automatic bit [67:0] m_expect();
    bit [3:0]  md;
    bit [15:0] dg;
    case (m_state)
      1: begin md = 4'hA; dg = m_a; end
      2: begin md = 4'hB; dg = m_b; end
      3: begin md = 4'h0; dg = {8'h0, m_op}; end
      default: begin md = 4'hC; dg = m_shown(); end
    endcase
    return {3'(m_state), m_a, m_b, m_op, md, dg, m_flags};
  endfunction

  task automatic do_press(bit commit, bit mod, bit [3:0] nib);
    sw = {commit, mod, 4'b0, nib};
    cont = 1'b0;
    repeat (HOLD) @(negedge clk);
    cont = 1'b1;
    repeat (HOLD) @(negedge clk);
    m_press(commit, mod, nib);
  endtask

  task automatic test_reset();
    reset = 1'b1; cont = 1'b1; sw = '0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, alu_a, alu_b, alu_op, digits, mode_digit, flag_leds} !== {3'd0, 16'h0, 16'h0, 8'h0, 16'h0, 4'hF, 5'h0}) begin
      failures++;
      $display("FAIL reset_state got st=%0d a=%h b=%h op=%h dig=%h mode=%h fl=%h", state, alu_a, alu_b, alu_op, digits, mode_digit, flag_leds);
    end
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    m_reset();
    checks++;
    if (state !== 3'd1 || mode_digit !== 4'hA) begin
      failures++;
      $display("FAIL reset_to_in_a got st=%0d mode=%h want st=1 mode=a", state, mode_digit);
    end
  endtask

  task automatic test_enter_a();
    do_press(0, 0, 4'h1); do_press(0, 0, 4'h2); do_press(0, 0, 4'h3); do_press(0, 0, 4'h4);
    do_press(1, 0, 4'h0);
    checks++;
    if (alu_a !== 16'h1234 || state !== 3'd2 || mode_digit !== 4'hB) begin
      failures++;
      $display("FAIL enter_a got a=%h st=%0d mode=%h want a=1234 st=2 mode=b", alu_a, state, mode_digit);
    end
  endtask

  task automatic test_full_sequence();
    do_press(0, 0, 4'h5); do_press(1, 0, 4'h0);
    do_press(0, 0, 4'h0); do_press(0, 0, 4'h1); do_press(1, 0, 4'h0);
    checks++;
    if (digits !== 16'h1239 || mode_digit !== 4'hC || state !== 3'd4) begin
      failures++;
      $display("FAIL full_seq got dig=%h mode=%h st=%0d want 1239 c 4", digits, mode_digit, state);
    end
    checks++;
    if (flag_leds !== 5'h01 || alu_op !== 8'h01 || alu_b !== 16'h0005) begin
      failures++;
      $display("FAIL full_seq_regs got fl=%h op=%h b=%h want 01 01 0005", flag_leds, alu_op, alu_b);
    end
  endtask

  task automatic test_chain();
    do_press(1, 1, 4'h0);
    checks++;
    if (alu_a !== 16'h1239 || alu_b !== 16'h0 || state !== 3'd2 || mode_digit !== 4'hB) begin
      failures++;
      $display("FAIL chain got a=%h b=%h st=%0d mode=%h want 1239 0000 2 b", alu_a, alu_b, state, mode_digit);
    end
  endtask

  task automatic test_clear();
    do_press(1, 0, 0); do_press(1, 0, 0); do_press(1, 0, 0);
    do_press(0, 1, 0); do_press(0, 0, 4'hA); do_press(0, 0, 4'hB);
    checks++;
    if (alu_a !== 16'h00AB || state !== 3'd1) begin
      failures++;
      $display("FAIL clear_setup got a=%h st=%0d want 00ab 1", alu_a, state);
    end
    do_press(0, 1, 4'h7);
    checks++;
    if (alu_a !== 16'h0000 || state !== 3'd1 || digits !== 16'h0) begin
      failures++;
      $display("FAIL clear got a=%h st=%0d dig=%h want 0000 1 0000", alu_a, state, digits);
    end
  endtask

  task automatic test_bounce();
    sw = {1'b0, 1'b0, 4'b0, 4'h5};
    for (int i = 0; i < 6; i++) begin
      cont = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (2) @(negedge clk);
    end
    checks++;
    if (alu_a !== 16'h0000) begin
      failures++;
      $display("FAIL bounce_no_press got a=%h want 0000", alu_a);
    end
    cont = 1'b0;
    repeat (10) @(negedge clk);
    cont = 1'b1;
    repeat (HOLD) @(negedge clk);
    m_press(0, 0, 4'h5);
    checks++;
    if (alu_a !== 16'h0005) begin
      failures++;
      $display("FAIL bounce_one_press got a=%h want 0005", alu_a);
    end
  endtask

  task automatic test_reset_mid();
    sw = {1'b0, 1'b0, 4'b0, 4'h9};
    cont = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({state, alu_a, alu_b, alu_op, digits, mode_digit, flag_leds} !== {3'd0, 16'h0, 16'h0, 8'h0, 16'h0, 4'hF, 5'h0}) begin
      failures++;
      $display("FAIL reset_mid got st=%0d a=%h b=%h op=%h dig=%h mode=%h", state, alu_a, alu_b, alu_op, digits, mode_digit);
    end
    repeat (2) @(negedge clk);
    cont = 1'b1;
    reset = 1'b1;
    repeat (HOLD) @(negedge clk);
    m_reset();
    checks++;
    if (state !== 3'd1 || alu_a !== 16'h0 || mode_digit !== 4'hA) begin
      failures++;
      $display("FAIL reset_mid_recover got st=%0d a=%h mode=%h want 1 0000 a", state, alu_a, mode_digit);
    end
  endtask

  task automatic test_show_view();
    bit [3:0]  rs [3];
    bit [15:0] want [4];
    rs[0] = 4'h3; rs[1] = 4'h7; rs[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      do_press(0, 1, 0); do_press(0, 0, rs[i]); do_press(1, 0, 0);
      do_press(0, 1, 0); do_press(1, 0, 0);
      do_press(1, 0, 0);
      if (i < 2) do_press(1, 0, 0);
    end
    checks++;
    if (digits !== 16'h000F || state !== 3'd4) begin
      failures++;
      $display("FAIL show_newest got dig=%h st=%0d want 000f 4", digits, state);
    end
`ifdef RESULT_HIST_EN
    want[0] = 16'h0007; want[1] = 16'h0003; want[2] = 16'h0000; want[3] = 16'h000F;
    for (int k = 0; k < 4; k++) begin
      do_press(0, 0, 0);
      checks++;
      if (digits !== want[k]) begin
        failures++;
        $display("FAIL hist_step%0d got dig=%h want %h", k, digits, want[k]);
      end
    end
`else
    want[0] = 16'h000F;
    do_press(0, 0, 0);
    checks++;
    if (digits !== want[0] || state !== 3'd4) begin
      failures++;
      $display("FAIL show_ignore got dig=%h st=%0d want %h 4", digits, state, want[0]);
    end
`endif
  endtask

  task automatic test_random();
    bit c, m;
    bit [3:0] n;
    bit [67:0] exp_v;
    for (int i = 0; i < 80; i++) begin
      c = ($urandom_range(0, 2) == 0);
      m = ($urandom_range(0, 3) == 0);
      n = 4'($urandom_range(0, 15));
      do_press(c, m, n);
      exp_v = m_expect();
      checks++;
      if ({state, alu_a, alu_b, alu_op, mode_digit, digits, flag_leds} !== exp_v) begin
        failures++;
        $display("FAIL rand%0d got st=%0d a=%h b=%h op=%h mode=%h dig=%h fl=%h want %h", i,
                 state, alu_a, alu_b, alu_op, mode_digit, digits, flag_leds, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enter_a();
    test_full_sequence();
    test_chain();
    test_clear();
    test_bounce();
    test_reset_mid();
    test_show_view();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
